// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: two-channel AXI-Stream arbiter in front of a UDP transmit layer.
// Build option: define UDP_ARB_FIXED_PRIO_EN for fixed ch0-over-ch1 priority (default round-robin).
module udp_tx_arbiter #(
    parameter logic [15:0] P_CH0_SRC_PORT = 16'h0808,
    parameter logic [15:0] P_CH0_DST_PORT = 16'h0808,
    parameter logic [15:0] P_CH1_SRC_PORT = 16'h0809,
    parameter logic [15:0] P_CH1_DST_PORT = 16'h0809,
    parameter int unsigned P_GAP_CYCLES   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic [63:0] s_axis_ch0_data,
    input  logic [31:0] s_axis_ch0_user,
    input  logic [7:0]  s_axis_ch0_keep,
    input  logic        s_axis_ch0_last,
    input  logic        s_axis_ch0_valid,
    output logic        s_axis_ch0_ready,

    input  logic [63:0] s_axis_ch1_data,
    input  logic [31:0] s_axis_ch1_user,
    input  logic [7:0]  s_axis_ch1_keep,
    input  logic        s_axis_ch1_last,
    input  logic        s_axis_ch1_valid,
    output logic        s_axis_ch1_ready,

    output logic [63:0] m_axis_user_data,
    output logic [31:0] m_axis_user_user,
    output logic [7:0]  m_axis_user_keep,
    output logic        m_axis_user_last,
    output logic        m_axis_user_valid,
    input  logic        m_axis_user_ready,

    output logic [15:0] o_dymanic_src_port,
    output logic        o_dymanic_src_valid,
    output logic [15:0] o_dymanic_dst_port,
    output logic        o_dymanic_dst_valid,
    output logic [1:0]  o_grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WAIT_RDY,
        S_XFER,
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(P_GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] src_port_q, src_port_d;
    logic [15:0] dst_port_q, dst_port_d;
    logic        win_ch1;
    logic        sel_valid;
    logic        sel_last;
    logic        pkt_end;
`ifndef UDP_ARB_FIXED_PRIO_EN
    logic        last_ch1_q, last_ch1_d;
`endif

`ifdef UDP_ARB_FIXED_PRIO_EN
    always_comb begin
        win_ch1 = s_axis_ch1_valid & ~s_axis_ch0_valid;
    end
`else
    // On contention the channel that was not served last takes the grant.
    always_comb begin
        win_ch1 = s_axis_ch1_valid & (~s_axis_ch0_valid | ~last_ch1_q);
    end
`endif

    always_comb begin
        sel_valid = grant_q[1] ? s_axis_ch1_valid : s_axis_ch0_valid;
        sel_last  = grant_q[1] ? s_axis_ch1_last  : s_axis_ch0_last;
        pkt_end   = (state_q == S_XFER) & sel_valid & sel_last & m_axis_user_ready;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            gap_cnt_q  <= '0;
            src_port_q <= P_CH0_SRC_PORT;
            dst_port_q <= P_CH0_DST_PORT;
`ifndef UDP_ARB_FIXED_PRIO_EN
            last_ch1_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gap_cnt_q  <= gap_cnt_d;
            src_port_q <= src_port_d;
            dst_port_q <= dst_port_d;
`ifndef UDP_ARB_FIXED_PRIO_EN
            last_ch1_q <= last_ch1_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gap_cnt_d  = gap_cnt_q;
        src_port_d = src_port_q;
        dst_port_d = dst_port_q;
`ifndef UDP_ARB_FIXED_PRIO_EN
        last_ch1_d = last_ch1_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (s_axis_ch0_valid | s_axis_ch1_valid) begin
                    state_d    = S_CFG;
                    grant_d    = win_ch1 ? 2'b10 : 2'b01;
                    src_port_d = win_ch1 ? P_CH1_SRC_PORT : P_CH0_SRC_PORT;
                    dst_port_d = win_ch1 ? P_CH1_DST_PORT : P_CH0_DST_PORT;
`ifndef UDP_ARB_FIXED_PRIO_EN
                    last_ch1_d = win_ch1;
`endif
                end
            end
            S_CFG: begin
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (m_axis_user_ready) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (pkt_end) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Zero-latency pass-through of the granted channel, only while in XFER.
    always_comb begin
        m_axis_user_data  = '0;
        m_axis_user_user  = '0;
        m_axis_user_keep  = '0;
        m_axis_user_last  = 1'b0;
        m_axis_user_valid = 1'b0;
        s_axis_ch0_ready  = 1'b0;
        s_axis_ch1_ready  = 1'b0;
        if (state_q == S_XFER) begin
            if (grant_q[1]) begin
                m_axis_user_data  = s_axis_ch1_data;
                m_axis_user_user  = s_axis_ch1_user;
                m_axis_user_keep  = s_axis_ch1_keep;
                m_axis_user_last  = s_axis_ch1_last;
                m_axis_user_valid = s_axis_ch1_valid;
                s_axis_ch1_ready  = m_axis_user_ready;
            end else begin
                m_axis_user_data  = s_axis_ch0_data;
                m_axis_user_user  = s_axis_ch0_user;
                m_axis_user_keep  = s_axis_ch0_keep;
                m_axis_user_last  = s_axis_ch0_last;
                m_axis_user_valid = s_axis_ch0_valid;
                s_axis_ch0_ready  = m_axis_user_ready;
            end
        end
    end

    always_comb begin
        o_dymanic_src_valid = (state_q == S_CFG);
        o_dymanic_dst_valid = (state_q == S_CFG);
        o_dymanic_src_port  = src_port_q;
        o_dymanic_dst_port  = dst_port_q;
        o_grant             = grant_q;
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed self-checking bench for udp_tx_arbiter.
// Define UDP_ARB_FIXED_PRIO_EN consistently for bench and design to check the fixed-priority build.
module tb_udp_tx_arbiter;

    localparam logic [15:0] P0 = 16'h0808;
    localparam logic [15:0] P1 = 16'h0809;

    logic        clk;
    logic        rst;
    logic [63:0] ch0_data, ch1_data, m_data;
    logic [31:0] ch0_user, ch1_user, m_user;
    logic [7:0]  ch0_keep, ch1_keep, m_keep;
    logic        ch0_last, ch1_last, m_last;
    logic        ch0_valid, ch1_valid, m_valid;
    logic        ch0_ready, ch1_ready, m_ready;
    logic [15:0] src_port, dst_port;
    logic        src_valid, dst_valid;
    logic [1:0]  grant;

    int unsigned total;
    int unsigned bad;

    udp_tx_arbiter #(
        .P_CH0_SRC_PORT(P0),
        .P_CH0_DST_PORT(P0),
        .P_CH1_SRC_PORT(P1),
        .P_CH1_DST_PORT(P1),
        .P_GAP_CYCLES  (4)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .s_axis_ch0_data     (ch0_data),
        .s_axis_ch0_user     (ch0_user),
        .s_axis_ch0_keep     (ch0_keep),
        .s_axis_ch0_last     (ch0_last),
        .s_axis_ch0_valid    (ch0_valid),
        .s_axis_ch0_ready    (ch0_ready),
        .s_axis_ch1_data     (ch1_data),
        .s_axis_ch1_user     (ch1_user),
        .s_axis_ch1_keep     (ch1_keep),
        .s_axis_ch1_last     (ch1_last),
        .s_axis_ch1_valid    (ch1_valid),
        .s_axis_ch1_ready    (ch1_ready),
        .m_axis_user_data    (m_data),
        .m_axis_user_user    (m_user),
        .m_axis_user_keep    (m_keep),
        .m_axis_user_last    (m_last),
        .m_axis_user_valid   (m_valid),
        .m_axis_user_ready   (m_ready),
        .o_dymanic_src_port  (src_port),
        .o_dymanic_src_valid (src_valid),
        .o_dymanic_dst_port  (dst_port),
        .o_dymanic_dst_valid (dst_valid),
        .o_grant             (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] dat(input logic [7:0] tag, input int unsigned i);
        return {tag, 24'h0, 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ch0_data = '0; ch0_user = '0; ch0_keep = '0; ch0_last = 1'b0; ch0_valid = 1'b0;
        ch1_data = '0; ch1_user = '0; ch1_keep = '0; ch1_last = 1'b0; ch1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        m_ready = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant: got %b want 00", grant); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        total++; if ({ch0_ready, ch1_ready} !== 2'b00) begin bad++; $display("FAIL rst_s_ready: got %b want 00", {ch0_ready, ch1_ready}); end
        total++; if ({src_valid, dst_valid} !== 2'b00) begin bad++; $display("FAIL rst_port_valid: got %b want 00", {src_valid, dst_valid}); end
        total++; if (src_port !== P0 || dst_port !== P0) begin bad++; $display("FAIL rst_ports: got %h/%h want %h/%h", src_port, dst_port, P0, P0); end
        tick();
        total++; if (m_data !== 64'h0) begin bad++; $display("FAIL rst_m_data: got %h want 0", m_data); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        m_ready   = 1'b1;
        ch0_valid = 1'b1; ch0_data = dat(8'hA0, 0); ch0_user = 32'd24; ch0_keep = 8'hFF; ch0_last = 1'b0;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_idle_grant: got %b want 00", grant); end
        tick();
        #1;
        total++; if ({src_valid, dst_valid} !== 2'b11) begin bad++; $display("FAIL single_cfg_strobe: got %b want 11", {src_valid, dst_valid}); end
        total++; if (src_port !== P0 || dst_port !== P0) begin bad++; $display("FAIL single_cfg_ports: got %h/%h want %h/%h", src_port, dst_port, P0, P0); end
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_cfg_grant: got %b want 01", grant); end
        total++; if (m_valid !== 1'b0 || ch0_ready !== 1'b0) begin bad++; $display("FAIL single_cfg_idle_bus: got %b%b want 00", m_valid, ch0_ready); end
        tick();
        #1;
        total++; if (m_valid !== 1'b0 || src_valid !== 1'b0) begin bad++; $display("FAIL single_wait: got %b%b want 00", m_valid, src_valid); end
        for (int unsigned b = 0; b < 3; b++) begin
            tick();
            ch0_data = dat(8'hA0, b);
            ch0_keep = (b == 2) ? 8'h0F : 8'hFF;
            ch0_last = (b == 2);
            #1;
            total++; if (m_valid !== 1'b1 || ch0_ready !== 1'b1) begin bad++; $display("FAIL single_beat%0d_hs: got %b%b want 11", b, m_valid, ch0_ready); end
            total++; if (m_data !== dat(8'hA0, b)) begin bad++; $display("FAIL single_beat%0d_data: got %h want %h", b, m_data, dat(8'hA0, b)); end
            total++; if (m_user !== 32'd24 || m_keep !== ch0_keep || m_last !== (b == 2)) begin bad++; $display("FAIL single_beat%0d_side: got %0d/%h/%b want 24/%h/%b", b, m_user, m_keep, m_last, ch0_keep, (b == 2)); end
        end
        tick();
        clear_inputs();
        for (int unsigned g = 0; g < 4; g++) begin
            #1;
            total++; if (grant !== 2'b01 || m_valid !== 1'b0) begin bad++; $display("FAIL single_gap%0d: got %b/%b want 01/0", g, grant, m_valid); end
            tick();
        end
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_back_idle: got %b want 00", grant); end
    endtask

    task automatic test_contention();
        int unsigned rem0, rem1, n, cyc;
        logic [1:0]  exp_g [8];
        logic [1:0]  cur;
        rem0 = 4; rem1 = 4; n = 0; cyc = 0; cur = 2'b00;
        for (int unsigned i = 0; i < 8; i++) begin
`ifdef UDP_ARB_FIXED_PRIO_EN
            exp_g[i] = (i < 4) ? 2'b01 : 2'b10;
`else
            exp_g[i] = i[0] ? 2'b10 : 2'b01;
`endif
        end
        do_reset();
        m_ready = 1'b1;
        while ((rem0 != 0 || rem1 != 0) && cyc < 300) begin
            ch0_valid = (rem0 != 0); ch0_data = dat(8'hC0, rem0); ch0_user = 32'd8; ch0_keep = 8'hFF; ch0_last = 1'b1;
            ch1_valid = (rem1 != 0); ch1_data = dat(8'hC1, rem1); ch1_user = 32'd8; ch1_keep = 8'hFF; ch1_last = 1'b1;
            #1;
            if (src_valid) begin
                total++;
                if (n >= 8) begin
                    bad++; $display("FAIL cont_extra_grant: got %b want none", grant);
                end else begin
                    cur = exp_g[n];
                    if (grant !== exp_g[n] || src_port !== (exp_g[n][1] ? P1 : P0)) begin
                        bad++; $display("FAIL cont_grant%0d: got %b/%h want %b/%h", n, grant, src_port, exp_g[n], exp_g[n][1] ? P1 : P0);
                    end
                end
                n++;
            end
            if (m_valid && m_ready) begin
                total++;
                if (cur == 2'b10) begin
                    if (m_data !== dat(8'hC1, rem1) || ch0_ready !== 1'b0) begin bad++; $display("FAIL cont_ch1_beat: got %h/%b want %h/0", m_data, ch0_ready, dat(8'hC1, rem1)); end
                    if (rem1 != 0) rem1--;
                end else begin
                    if (m_data !== dat(8'hC0, rem0) || ch1_ready !== 1'b0) begin bad++; $display("FAIL cont_ch0_beat: got %h/%b want %h/0", m_data, ch1_ready, dat(8'hC0, rem0)); end
                    if (rem0 != 0) rem0--;
                end
            end
            tick();
            cyc++;
        end
        total++; if (rem0 != 0 || rem1 != 0 || n != 8) begin bad++; $display("FAIL cont_done: got rem %0d/%0d grants %0d want 0/0 8", rem0, rem1, n); end
    endtask

    task automatic test_backpressure();
        logic [6:0]  bp;
        int unsigned idx, cyc;
        bp = 7'b1011001;
        idx = 0; cyc = 0;
        do_reset();
        m_ready   = 1'b0;
        ch0_valid = 1'b1; ch0_data = dat(8'hB0, 0); ch0_user = 32'd24; ch0_keep = 8'hFF; ch0_last = 1'b0;
        tick();
        #1;
        total++; if (src_valid !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL bp_cfg: got %b%b want 10", src_valid, m_valid); end
        for (int unsigned w = 0; w < 3; w++) begin
            tick();
            #1;
            total++; if (m_valid !== 1'b0 || ch0_ready !== 1'b0 || src_valid !== 1'b0 || grant !== 2'b01) begin
                bad++; $display("FAIL bp_wait%0d: got %b%b%b/%b want 000/01", w, m_valid, ch0_ready, src_valid, grant);
            end
        end
        tick();
        m_ready = 1'b1;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_wait_exit: got %b want 0", m_valid); end
        while (idx < 3 && cyc < 20) begin
            tick();
            m_ready  = bp[cyc % 7];
            ch0_data = dat(8'hB0, idx);
            ch0_last = (idx == 2);
            #1;
            total++; if (ch0_ready !== m_ready || m_valid !== 1'b1) begin bad++; $display("FAIL bp_ready_c%0d: got %b/%b want %b/1", cyc, ch0_ready, m_valid, m_ready); end
            total++; if (m_data !== dat(8'hB0, idx)) begin bad++; $display("FAIL bp_data_c%0d: got %h want %h", cyc, m_data, dat(8'hB0, idx)); end
            if (m_ready) idx++;
            cyc++;
        end
        total++; if (idx != 3) begin bad++; $display("FAIL bp_beats: got %0d want 3", idx); end
        tick();
        clear_inputs();
        #1;
        total++; if (m_valid !== 1'b0 || grant !== 2'b01) begin bad++; $display("FAIL bp_gap: got %b/%b want 0/01", m_valid, grant); end
    endtask

    task automatic test_stall();
        int unsigned k;
        logic        found;
        k = 0; found = 1'b0;
        do_reset();
        m_ready   = 1'b1;
        ch1_valid = 1'b1; ch1_data = dat(8'hD1, 0); ch1_user = 32'd32; ch1_keep = 8'hFF; ch1_last = 1'b0;
        tick();
        #1;
        total++; if (src_valid !== 1'b1 || grant !== 2'b10 || src_port !== P1 || dst_port !== P1) begin
            bad++; $display("FAIL stall_cfg: got %b/%b/%h/%h want 1/10/%h/%h", src_valid, grant, src_port, dst_port, P1, P1);
        end
        tick();
        for (int unsigned b = 0; b < 2; b++) begin
            tick();
            ch1_data = dat(8'hD1, b);
            #1;
            total++; if (m_data !== dat(8'hD1, b) || ch1_ready !== 1'b1) begin bad++; $display("FAIL stall_pre%0d: got %h/%b want %h/1", b, m_data, ch1_ready, dat(8'hD1, b)); end
        end
        for (int unsigned s = 0; s < 5; s++) begin
            tick();
            ch1_valid = 1'b0;
            ch0_valid = 1'b1; ch0_data = dat(8'hD0, 0); ch0_user = 32'd8; ch0_keep = 8'hFF; ch0_last = 1'b1;
            #1;
            total++; if (grant !== 2'b10 || ch0_ready !== 1'b0 || m_valid !== 1'b0 || src_valid !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d: got %b/%b%b%b want 10/000", s, grant, ch0_ready, m_valid, src_valid);
            end
        end
        for (int unsigned b = 2; b < 4; b++) begin
            tick();
            ch1_valid = 1'b1; ch1_data = dat(8'hD1, b); ch1_last = (b == 3);
            #1;
            total++; if (m_data !== dat(8'hD1, b) || m_last !== (b == 3) || ch0_ready !== 1'b0) begin
                bad++; $display("FAIL stall_post%0d: got %h/%b/%b want %h/%b/0", b, m_data, m_last, ch0_ready, dat(8'hD1, b), (b == 3));
            end
        end
        tick();
        ch1_valid = 1'b0;
        while (!found && k < 10) begin
            #1;
            if (src_valid) begin
                found = 1'b1;
                total++; if (grant !== 2'b01 || src_port !== P0) begin bad++; $display("FAIL stall_next_grant: got %b/%h want 01/%h", grant, src_port, P0); end
            end else begin
                tick();
                k++;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL stall_next_cfg: got none want strobe"); end
        total++; if (k != 5) begin bad++; $display("FAIL stall_gap_len: got %0d want 5", k); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_ready   = 1'b1;
        ch1_valid = 1'b1; ch1_data = dat(8'hE1, 0); ch1_user = 32'd32; ch1_keep = 8'hFF; ch1_last = 1'b0;
        tick();
        tick();
        tick();
        #1;
        total++; if (m_valid !== 1'b1 || m_data !== dat(8'hE1, 0)) begin bad++; $display("FAIL rmid_beat1: got %b/%h want 1/%h", m_valid, m_data, dat(8'hE1, 0)); end
        tick();
        ch1_data = dat(8'hE1, 1);
        #1;
        total++; if (m_data !== dat(8'hE1, 1)) begin bad++; $display("FAIL rmid_beat2: got %h want %h", m_data, dat(8'hE1, 1)); end
        #1 rst = 1'b1;
        #1;
        total++; if (m_valid !== 1'b0 || ch1_ready !== 1'b0 || grant !== 2'b00 || m_data !== 64'h0) begin
            bad++; $display("FAIL rmid_async: got %b/%b/%b/%h want 0/0/00/0", m_valid, ch1_ready, grant, m_data);
        end
        total++; if (src_port !== P0 || dst_port !== P0) begin bad++; $display("FAIL rmid_ports: got %h/%h want %h/%h", src_port, dst_port, P0, P0); end
        tick();
        rst = 1'b0;
        ch1_data = dat(8'hF1, 0);
        #1;
        total++; if (grant !== 2'b00 || m_valid !== 1'b0) begin bad++; $display("FAIL rmid_idle: got %b/%b want 00/0", grant, m_valid); end
        tick();
        #1;
        total++; if (src_valid !== 1'b1 || grant !== 2'b10 || src_port !== P1) begin bad++; $display("FAIL rmid_fresh_cfg: got %b/%b/%h want 1/10/%h", src_valid, grant, src_port, P1); end
        tick();
        tick();
        #1;
        total++; if (m_valid !== 1'b1 || m_data !== dat(8'hF1, 0)) begin bad++; $display("FAIL rmid_fresh_beat: got %b/%h want 1/%h", m_valid, m_data, dat(8'hF1, 0)); end
        clear_inputs();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        m_ready = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
